// File: rtl/ucode_pkg.sv
// Shared types and helpers for the microcode sequencer.
// onehot_dec covers the widest supported opcode; callers cast the result down to their NOUT.
package ucode_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int UCODE_OPW    = 4;
  localparam int UCODE_CNTW   = 4;
  localparam int UCODE_MAXOPW = 8;
  localparam int UCODE_MAXN   = 1 << UCODE_MAXOPW;

  function automatic logic [UCODE_MAXN-1:0] onehot_dec(input logic [UCODE_MAXOPW-1:0] opcode);
    onehot_dec = '0;
    onehot_dec[opcode] = 1'b1;
  endfunction

endpackage

// File: rtl/ucode_sequencer.sv
// Registered microcode sequencer: holds a one-hot PIM command for count+1 un-stalled cycles,
// or emits a single ctrl_pulse for control words.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int OPW  = UCODE_OPW,
  parameter int CNTW = UCODE_CNTW,
  localparam int NOUT = 1 << OPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cw_valid,
  output logic            cw_ready,
  input  logic [OPW-1:0]  cw_opcode,
  input  logic [CNTW-1:0] cw_count,
  input  logic            cw_pim,
  input  logic            op_stall,
  output logic [NOUT-1:0] decoder_out,
  output logic            op_valid,
  output logic            op_last,
  output logic            ctrl_pulse,
  output logic            busy
);

  state_t          state;
  logic [CNTW-1:0] remaining;
  logic [NOUT-1:0] dec;
  logic            accept;

  assign dec      = NOUT'(onehot_dec(UCODE_MAXOPW'(cw_opcode)));
  // Ready on the final un-stalled issue cycle gives back-to-back words with no bubble.
  assign cw_ready = (state == IDLE) | ((state == ISSUE) & op_last & ~op_stall);
  assign accept   = cw_valid & cw_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      decoder_out <= '0;
      op_valid    <= 1'b0;
      op_last     <= 1'b0;
      ctrl_pulse  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ctrl_pulse <= 1'b0;
      if (accept) begin
        if (cw_pim) begin
          state       <= ISSUE;
          remaining   <= cw_count;
          decoder_out <= dec;
          op_valid    <= 1'b1;
          op_last     <= (cw_count == '0);
          busy        <= 1'b1;
        end else begin
          state       <= IDLE;
          remaining   <= '0;
          decoder_out <= '0;
          op_valid    <= 1'b0;
          op_last     <= 1'b0;
          busy        <= 1'b0;
          ctrl_pulse  <= 1'b1;
        end
      end else if ((state == ISSUE) && !op_stall) begin
        if (remaining != '0) begin
          remaining <= remaining - CNTW'(1);
          op_last   <= (remaining == CNTW'(1));
        end else begin
          state       <= IDLE;
          decoder_out <= '0;
          op_valid    <= 1'b0;
          op_last     <= 1'b0;
          busy        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: a cycle-level model checked every negedge,
// plus hand-computed literal expectations for each scenario.
module tb_ucode_sequencer;

  localparam int OPW  = 4;
  localparam int CNTW = 4;
  localparam int NOUT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cw_valid = 1'b0;
  logic            cw_ready;
  logic [OPW-1:0]  cw_opcode = '0;
  logic [CNTW-1:0] cw_count = '0;
  logic            cw_pim = 1'b0;
  logic            op_stall = 1'b0;
  logic [NOUT-1:0] decoder_out;
  logic            op_valid, op_last, ctrl_pulse, busy;

  ucode_sequencer #(.OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .cw_opcode(cw_opcode), .cw_count(cw_count), .cw_pim(cw_pim),
    .op_stall(op_stall), .decoder_out(decoder_out), .op_valid(op_valid),
    .op_last(op_last), .ctrl_pulse(ctrl_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: a word occupies "cycles_left" issue cycles (count+1), ticking down on un-stalled edges.
  bit m_issuing = 1'b0;
  int m_left = 0;
  int m_opc = 0;
  bit m_pulse = 1'b0;

  function automatic bit m_ready();
    return !m_issuing || (m_left == 1 && !op_stall);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_issuing = 1'b0; m_left = 0; m_opc = 0; m_pulse = 1'b0;
    end else begin
      bit acc;
      acc = cw_valid && m_ready();
      m_pulse = 1'b0;
      if (acc) begin
        if (cw_pim) begin
          m_issuing = 1'b1; m_left = int'(cw_count) + 1; m_opc = int'(cw_opcode);
        end else begin
          m_issuing = 1'b0; m_left = 0; m_pulse = 1'b1;
        end
      end else if (m_issuing && !op_stall) begin
        m_left--;
        if (m_left == 0) m_issuing = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] edec;
      edec = m_issuing ? (32'd1 << m_opc) : 32'd0;
      chk("m_decoder_out", {16'd0, decoder_out}, edec);
      chk("m_op_valid", {31'd0, op_valid}, {31'd0, m_issuing});
      chk("m_op_last", {31'd0, op_last}, {31'd0, (m_issuing && m_left == 1)});
      chk("m_ctrl_pulse", {31'd0, ctrl_pulse}, {31'd0, m_pulse});
      chk("m_busy", {31'd0, busy}, {31'd0, m_issuing});
      chk("m_cw_ready", {31'd0, cw_ready}, {31'd0, m_ready()});
      chk("m_onehot0", {31'd0, $onehot0(decoder_out)}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic pim, input int opc, input int cnt);
    cw_valid = 1'b1; cw_pim = pim;
    cw_opcode = OPW'(opc); cw_count = CNTW'(cnt);
  endtask

  initial begin
    int n_on, n_last;
    // Reset held with a valid word pending: nothing may be accepted.
    rst = 1'b1;
    send(1'b1, 2, 0);
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_dec", {16'd0, decoder_out}, 32'h0);
    chk("rst_valid", {31'd0, op_valid}, 32'd0);
    cw_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_dec", {16'd0, decoder_out}, 32'h0);
    chk("idle_ready", {31'd0, cw_ready}, 32'd1);

    // Single PIM word, opcode 5, count 0.
    send(1'b1, 5, 0);
    tick();
    cw_valid = 1'b0;
    chk("single_dec", {16'd0, decoder_out}, 32'h0020);
    chk("single_last", {31'd0, op_last}, 32'd1);
    tick();
    chk("single_done", {31'd0, op_valid}, 32'd0);

    // opcode 3, count 2, stalled on the second issue cycle.
    send(1'b1, 3, 2);
    tick();
    cw_valid = 1'b0;
    n_on = 0; n_last = 0;
    for (int i = 0; i < 8; i++) begin
      if (decoder_out == 16'h0008) n_on++;
      if (op_last) n_last++;
      if (i == 1) begin
        op_stall = 1'b1;
        #1 chk("stall_ready", {31'd0, cw_ready}, 32'd0);
      end else op_stall = 1'b0;
      tick();
    end
    chk("stall_on_cycles", n_on, 32'd4);
    chk("stall_last_cycles", n_last, 32'd1);

    // Back-to-back words with cw_valid held.
    send(1'b1, 1, 1);
    tick();
    chk("b2b_c1", {16'd0, decoder_out}, 32'h0002);
    send(1'b1, 15, 0);
    tick();
    chk("b2b_c2", {16'd0, decoder_out}, 32'h0002);
    chk("b2b_ready", {31'd0, cw_ready}, 32'd1);
    tick();
    cw_valid = 1'b0;
    chk("b2b_c3", {16'd0, decoder_out}, 32'h8000);
    chk("b2b_c3_last", {31'd0, op_last}, 32'd1);
    tick();

    // Control word from idle.
    send(1'b0, 7, 0);
    tick();
    cw_valid = 1'b0;
    chk("ctrl_pulse", {31'd0, ctrl_pulse}, 32'd1);
    chk("ctrl_dec", {16'd0, decoder_out}, 32'h0);
    tick();
    chk("ctrl_pulse_off", {31'd0, ctrl_pulse}, 32'd0);

    // Control word right behind a PIM word's last cycle.
    send(1'b1, 4, 0);
    tick();
    send(1'b0, 7, 0);
    tick();
    cw_valid = 1'b0;
    chk("ctrl_after_pim", {31'd0, ctrl_pulse}, 32'd1);
    chk("ctrl_after_pim_v", {31'd0, op_valid}, 32'd0);
    tick();

    // Reset in the middle of a long word.
    send(1'b1, 9, 10);
    tick();
    cw_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_dec", {16'd0, decoder_out}, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("midrst_stays_idle", {31'd0, op_valid}, 32'd0);

    // Maximum count gives 2^CNTW issue cycles.
    send(1'b1, 0, 15);
    tick();
    cw_valid = 1'b0;
    n_on = 0;
    for (int i = 0; i < 20; i++) begin
      if (decoder_out == 16'h0001) n_on++;
      tick();
    end
    chk("maxcnt_cycles", n_on, 32'd16);

    // Pseudo-random traffic checked by the model only.
    for (int i = 0; i < 300; i++) begin
      cw_valid  = 1'($urandom_range(0, 1));
      cw_pim    = ($urandom_range(0, 3) != 0);
      cw_opcode = OPW'($urandom);
      cw_count  = CNTW'($urandom_range(0, 3));
      op_stall  = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0; cw_valid = 1'b0; op_stall = 1'b0;
    repeat (3) tick();

    @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
